game_round_controller: RTL and testbench

GAME_ROUND_CONTROLLER -- requirements
Module: game_round_controller

---
 rtl/game_round_controller.sv | 176 +++++++++++++++++
 tb/tb_game_round_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_controller.sv
// Round controller for a two-player arrow-matching game: countdown, pattern windows, hit judging.
// Optional MISS_COUNT_EN adds miss_a/miss_b pulses when a window closes without a hit.
module game_round_controller #(
    parameter int ROUND_PATTERNS   = 32,
    parameter int HIT_WINDOW       = 12500000,
    parameter int COUNTDOWN_CYCLES = 150000000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] pattern_in,
    input  logic       pattern_valid,
    input  logic [3:0] player_a_keys,
    input  logic [3:0] player_b_keys,
    output logic       game_active,
    output logic       perfect_hit_a,
    output logic       perfect_hit_b,
    output logic [3:0] target,
    output logic       window_open,
    output logic [1:0] state,
    output logic [5:0] patterns_left,
`ifdef MISS_COUNT_EN
    output logic       miss_a,
    output logic       miss_b,
`endif
    output logic       round_done
);

    localparam int CD_W  = (COUNTDOWN_CYCLES > 1) ? $clog2(COUNTDOWN_CYCLES) : 1;
    localparam int WIN_W = $clog2(HIT_WINDOW + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_COUNTDOWN = 2'b01,
        S_PLAY      = 2'b10,
        S_GAME_OVER = 2'b11
    } state_t;

    state_t            state_q;
    logic [CD_W-1:0]   cd_cnt_q;
    logic [WIN_W-1:0]  win_cnt_q;
    logic              window_open_q;
    logic [3:0]        target_q;
    logic [5:0]        patterns_left_q;
    logic              start_prev_q;
    logic [3:0]        keys_a_prev_q;
    logic [3:0]        keys_b_prev_q;
    logic              flag_a_q;
    logic              flag_b_q;
    logic              perfect_hit_a_q;
    logic              perfect_hit_b_q;
    logic              game_active_q;
    logic              round_done_q;
`ifdef MISS_COUNT_EN
    logic              miss_a_q;
    logic              miss_b_q;
`endif

    logic start_rise;
    logic accept;
    logic win_last;
    logic win_close;
    logic hit_a_d;
    logic hit_b_d;
    logic unused_pattern_hi;

    assign unused_pattern_hi = ^pattern_in[7:4];

    // pattern_valid is a one-cycle qualifier with no back-pressure; it only counts in PLAY with patterns left.
    always_comb begin
        start_rise = start && !start_prev_q;
        accept     = pattern_valid && (state_q == S_PLAY) && (patterns_left_q != 6'd0);
        win_last   = window_open_q && (win_cnt_q == WIN_W'(1));
        win_close  = accept ? window_open_q : win_last;
        // A hit needs a fresh press that exactly matches; a replacing pattern voids that cycle's keys.
        hit_a_d    = window_open_q && !accept && !flag_a_q &&
                     (player_a_keys == target_q) && (keys_a_prev_q != target_q);
        hit_b_d    = window_open_q && !accept && !flag_b_q &&
                     (player_b_keys == target_q) && (keys_b_prev_q != target_q);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            cd_cnt_q        <= '0;
            win_cnt_q       <= '0;
            window_open_q   <= 1'b0;
            target_q        <= 4'd0;
            patterns_left_q <= 6'd0;
            start_prev_q    <= 1'b0;
            keys_a_prev_q   <= 4'd0;
            keys_b_prev_q   <= 4'd0;
            flag_a_q        <= 1'b0;
            flag_b_q        <= 1'b0;
            perfect_hit_a_q <= 1'b0;
            perfect_hit_b_q <= 1'b0;
            game_active_q   <= 1'b0;
            round_done_q    <= 1'b0;
`ifdef MISS_COUNT_EN
            miss_a_q        <= 1'b0;
            miss_b_q        <= 1'b0;
`endif
        end else begin
            start_prev_q    <= start;
            keys_a_prev_q   <= player_a_keys;
            keys_b_prev_q   <= player_b_keys;
            perfect_hit_a_q <= hit_a_d;
            perfect_hit_b_q <= hit_b_d;
            if (hit_a_d) flag_a_q <= 1'b1;
            if (hit_b_d) flag_b_q <= 1'b1;
`ifdef MISS_COUNT_EN
            miss_a_q <= win_close && !(flag_a_q || hit_a_d);
            miss_b_q <= win_close && !(flag_b_q || hit_b_d);
`endif

            if (accept) begin
                target_q        <= pattern_in[3:0];
                win_cnt_q       <= WIN_W'(HIT_WINDOW);
                window_open_q   <= 1'b1;
                flag_a_q        <= 1'b0;
                flag_b_q        <= 1'b0;
                patterns_left_q <= patterns_left_q - 6'd1;
            end else if (window_open_q) begin
                if (win_last) begin
                    window_open_q <= 1'b0;
                    win_cnt_q     <= '0;
                end else begin
                    win_cnt_q <= win_cnt_q - WIN_W'(1);
                end
            end

            case (state_q)
                S_IDLE, S_GAME_OVER: begin
                    if (start_rise) begin
                        state_q         <= S_COUNTDOWN;
                        cd_cnt_q        <= CD_W'(COUNTDOWN_CYCLES - 1);
                        patterns_left_q <= 6'(ROUND_PATTERNS);
                        target_q        <= 4'd0;
                        game_active_q   <= 1'b0;
                        round_done_q    <= 1'b0;
                    end
                end
                S_COUNTDOWN: begin
                    if (cd_cnt_q == '0) begin
                        state_q       <= S_PLAY;
                        game_active_q <= 1'b1;
                    end else begin
                        cd_cnt_q <= cd_cnt_q - CD_W'(1);
                    end
                end
                S_PLAY: begin
                    if ((patterns_left_q == 6'd0) && !window_open_q && !pattern_valid) begin
                        state_q       <= S_GAME_OVER;
                        game_active_q <= 1'b0;
                        round_done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state         = state_q;
    assign game_active   = game_active_q;
    assign round_done    = round_done_q;
    assign window_open   = window_open_q;
    assign target        = target_q;
    assign patterns_left = patterns_left_q;
    assign perfect_hit_a = perfect_hit_a_q;
    assign perfect_hit_b = perfect_hit_b_q;
`ifdef MISS_COUNT_EN
    assign miss_a        = miss_a_q;
    assign miss_b        = miss_b_q;
`endif

endmodule

// File: tb/tb_game_round_controller.sv
// Directed table-driven bench for game_round_controller (ROUND_PATTERNS=2, HIT_WINDOW=4, COUNTDOWN_CYCLES=3).
module tb_game_round_controller;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [7:0] pattern_in;
    logic       pattern_valid;
    logic [3:0] player_a_keys;
    logic [3:0] player_b_keys;
    logic       game_active;
    logic       perfect_hit_a;
    logic       perfect_hit_b;
    logic [3:0] target;
    logic       window_open;
    logic [1:0] state;
    logic [5:0] patterns_left;
    logic       round_done;
`ifdef MISS_COUNT_EN
    logic       miss_a;
    logic       miss_b;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    game_round_controller #(
        .ROUND_PATTERNS  (2),
        .HIT_WINDOW      (4),
        .COUNTDOWN_CYCLES(3)
    ) dut (
        .CLOCK_50     (clk),
        .resetn       (resetn),
        .start        (start),
        .pattern_in   (pattern_in),
        .pattern_valid(pattern_valid),
        .player_a_keys(player_a_keys),
        .player_b_keys(player_b_keys),
        .game_active  (game_active),
        .perfect_hit_a(perfect_hit_a),
        .perfect_hit_b(perfect_hit_b),
        .target       (target),
        .window_open  (window_open),
        .state        (state),
        .patterns_left(patterns_left),
`ifdef MISS_COUNT_EN
        .miss_a       (miss_a),
        .miss_b       (miss_b),
`endif
        .round_done   (round_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st_in;
        logic       pv;
        logic [7:0] pin;
        logic [3:0] ka;
        logic [3:0] kb;
        logic [1:0] e_state;
        logic       e_ga;
        logic       e_rd;
        logic       e_wo;
        logic [3:0] e_tg;
        logic [5:0] e_pl;
        logic       e_ha;
        logic       e_hb;
        logic       e_ma;
        logic       e_mb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic pv, input logic [7:0] pin,
                       input logic [3:0] ka, input logic [3:0] kb,
                       input logic [1:0] st, input logic ga, input logic rd, input logic wo,
                       input logic [3:0] tg, input logic [5:0] pl,
                       input logic ha, input logic hb, input logic ma, input logic mb);
        vec_t v;
        v.st_in = s;   v.pv = pv;   v.pin = pin;  v.ka = ka;   v.kb = kb;
        v.e_state = st; v.e_ga = ga; v.e_rd = rd; v.e_wo = wo; v.e_tg = tg;
        v.e_pl = pl;   v.e_ha = ha; v.e_hb = hb;  v.e_ma = ma; v.e_mb = mb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic pv, input logic [7:0] pin,
                         input logic [3:0] ka, input logic [3:0] kb);
        start = s; pattern_valid = pv; pattern_in = pin;
        player_a_keys = ka; player_b_keys = kb;
    endtask

    task automatic check_all_zero(input int step);
        check("rst_state", step, {6'd0, state}, 8'd0);
        check("rst_active", step, {7'd0, game_active}, 8'd0);
        check("rst_done", step, {7'd0, round_done}, 8'd0);
        check("rst_window", step, {7'd0, window_open}, 8'd0);
        check("rst_target", step, {4'd0, target}, 8'd0);
        check("rst_left", step, {2'd0, patterns_left}, 8'd0);
        check("rst_hit_a", step, {7'd0, perfect_hit_a}, 8'd0);
        check("rst_hit_b", step, {7'd0, perfect_hit_b}, 8'd0);
`ifdef MISS_COUNT_EN
        check("rst_miss_a", step, {7'd0, miss_a}, 8'd0);
        check("rst_miss_b", step, {7'd0, miss_b}, 8'd0);
`endif
    endtask

    initial begin
        int cycles;

        resetn = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 4'h0, 4'h0);

        // Round 1: countdown, A hit + ignored re-press, unhit second window, game over, ignored third pattern.
        //   s  pv pin    ka    kb     st     ga rd wo tg    pl    ha hb ma mb
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b00, 0, 0, 0, 4'h0, 6'd0, 0, 0, 0, 0);
        add(1, 0, 8'h00, 4'h0, 4'h0, 2'b01, 0, 0, 0, 4'h0, 6'd2, 0, 0, 0, 0);
        add(1, 0, 8'h00, 4'h0, 4'h0, 2'b01, 0, 0, 0, 4'h0, 6'd2, 0, 0, 0, 0);
        add(1, 0, 8'h00, 4'h0, 4'h0, 2'b01, 0, 0, 0, 4'h0, 6'd2, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b10, 1, 0, 0, 4'h0, 6'd2, 0, 0, 0, 0);
        add(0, 1, 8'hAA, 4'h0, 4'h0, 2'b10, 1, 0, 1, 4'hA, 6'd1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'hA, 4'h0, 2'b10, 1, 0, 1, 4'hA, 6'd1, 1, 0, 0, 0);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b10, 1, 0, 1, 4'hA, 6'd1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'hA, 4'h0, 2'b10, 1, 0, 1, 4'hA, 6'd1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b10, 1, 0, 0, 4'hA, 6'd1, 0, 0, 0, 1);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b10, 1, 0, 0, 4'hA, 6'd1, 0, 0, 0, 0);
        add(0, 1, 8'h55, 4'h0, 4'h0, 2'b10, 1, 0, 1, 4'h5, 6'd0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b10, 1, 0, 1, 4'h5, 6'd0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b10, 1, 0, 1, 4'h5, 6'd0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b10, 1, 0, 1, 4'h5, 6'd0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b10, 1, 0, 0, 4'h5, 6'd0, 0, 0, 1, 1);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b11, 0, 1, 0, 4'h5, 6'd0, 0, 0, 0, 0);
        add(0, 1, 8'hFF, 4'h0, 4'h0, 2'b11, 0, 1, 0, 4'h5, 6'd0, 0, 0, 0, 0);
        // Round 2 from GAME_OVER: B wrong keys, simultaneous hits, replacement, A-only hit.
        add(1, 0, 8'h00, 4'h0, 4'h0, 2'b01, 0, 0, 0, 4'h0, 6'd2, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b01, 0, 0, 0, 4'h0, 6'd2, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b01, 0, 0, 0, 4'h0, 6'd2, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b10, 1, 0, 0, 4'h0, 6'd2, 0, 0, 0, 0);
        add(0, 1, 8'hAA, 4'h0, 4'hF, 2'b10, 1, 0, 1, 4'hA, 6'd1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'h0, 4'hF, 2'b10, 1, 0, 1, 4'hA, 6'd1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'hA, 4'hA, 2'b10, 1, 0, 1, 4'hA, 6'd1, 1, 1, 0, 0);
        add(0, 1, 8'h55, 4'h5, 4'h5, 2'b10, 1, 0, 1, 4'h5, 6'd0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'h5, 4'h5, 2'b10, 1, 0, 1, 4'h5, 6'd0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b10, 1, 0, 1, 4'h5, 6'd0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'h5, 4'h0, 2'b10, 1, 0, 1, 4'h5, 6'd0, 1, 0, 0, 0);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b10, 1, 0, 0, 4'h5, 6'd0, 0, 0, 0, 1);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b11, 0, 1, 0, 4'h5, 6'd0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 4'h0, 4'h0, 2'b11, 0, 1, 0, 4'h5, 6'd0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_all_zero(-1);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].st_in, vecs[i].pv, vecs[i].pin, vecs[i].ka, vecs[i].kb);
            @(posedge clk);
            #1;
            check("state", i, {6'd0, state}, {6'd0, vecs[i].e_state});
            check("game_active", i, {7'd0, game_active}, {7'd0, vecs[i].e_ga});
            check("round_done", i, {7'd0, round_done}, {7'd0, vecs[i].e_rd});
            check("window_open", i, {7'd0, window_open}, {7'd0, vecs[i].e_wo});
            check("target", i, {4'd0, target}, {4'd0, vecs[i].e_tg});
            check("patterns_left", i, {2'd0, patterns_left}, {2'd0, vecs[i].e_pl});
            check("perfect_hit_a", i, {7'd0, perfect_hit_a}, {7'd0, vecs[i].e_ha});
            check("perfect_hit_b", i, {7'd0, perfect_hit_b}, {7'd0, vecs[i].e_hb});
`ifdef MISS_COUNT_EN
            check("miss_a", i, {7'd0, miss_a}, {7'd0, vecs[i].e_ma});
            check("miss_b", i, {7'd0, miss_b}, {7'd0, vecs[i].e_mb});
`endif
        end

        // Round 3: start from GAME_OVER, bounded wait for PLAY, then asynchronous reset mid-window.
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h00, 4'h0, 4'h0);
        @(posedge clk);
        #1;
        check("r3_countdown", 100, {6'd0, state}, 8'h01);
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (!game_active && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("r3_countdown_len", 101, 8'(cycles), 8'd3);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h3C, 4'h0, 4'h0);
        @(posedge clk);
        #1;
        check("r3_window", 102, {7'd0, window_open}, 8'd1);
        check("r3_target", 102, {4'd0, target}, 8'h0C);
        @(negedge clk);
        pattern_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero(103);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", 104, {6'd0, state}, 8'h00);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("restart_state", 105, {6'd0, state}, 8'h01);
        check("restart_left", 105, {2'd0, patterns_left}, 8'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
